// File: rtl/game_pkg.sv
// Shared definitions for the sequence-memory game.
// Contents: round-sequencer state encoding, symbol and level widths,
// level thresholds for the timer speed buckets, and the level-to-speed helper.
package game_pkg;

  localparam int SYM_W = 2;
  localparam int LVL_W = 5;

  // Upper level bound (inclusive) of speed buckets 0, 1 and 2.
  localparam logic [LVL_W-1:0] SPD_T1 = 5'd4;
  localparam logic [LVL_W-1:0] SPD_T2 = 5'd8;
  localparam logic [LVL_W-1:0] SPD_T3 = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXTEND,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_WIN,
    ST_LOSE
  } state_t;

  function automatic logic [1:0] speed_of(input logic [LVL_W-1:0] lvl);
    if (lvl <= SPD_T1)      return 2'd0;
    else if (lvl <= SPD_T2) return 2'd1;
    else if (lvl <= SPD_T3) return 2'd2;
    else                    return 2'd3;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, advancing every clock.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, loads SEED
//   value  - current register contents
// A nonzero SEED keeps the register out of the all-zero lock-up state.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value_q <= SEED;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer for the sequence-memory game.
// Each round appends one pseudo-random symbol, replays the whole sequence
// through show_valid/show_symbol, then checks player presses under a
// per-press timeout using the downstream timer.
// Ports:
//   clock, reset            - clock; asynchronous active-low reset
//   new_game                - (re)start pulse, highest priority
//   btn_valid, btn_symbol   - player press pulse and symbol
//   timer_done              - timer expiry flag
//   timer_start/stop        - one-cycle timer control pulses
//   timer_speed, timer_max  - timer tick rate and current phase limit
//   show_valid, show_symbol - symbol display
//   level, score            - sequence length, completed rounds
//   game_over, win          - LOSE / WIN status
// All outputs are registered; they are computed from the next state.
module round_controller
  import game_pkg::*;
#(
  parameter int          MAX_LEN     = 16,
  parameter logic [5:0]  SHOW_TICKS  = 6'd2,
  parameter logic [5:0]  GAP_TICKS   = 6'd1,
  parameter logic [5:0]  INPUT_TICKS = 6'd5,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       btn_valid,
  input  logic [1:0] btn_symbol,
  input  logic       timer_done,
  output logic       timer_start,
  output logic       timer_stop,
  output logic [1:0] timer_speed,
  output logic [5:0] timer_max,
  output logic       show_valid,
  output logic [1:0] show_symbol,
  output logic [4:0] level,
  output logic [4:0] score,
  output logic       game_over,
  output logic       win
);

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEN);

  state_t                   state_q, state_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [LVL_W-1:0]         score_q, score_d;
  logic [LVL_W-1:0]         idx_q, idx_d;
  logic                     timer_start_q, timer_start_d;
  logic                     timer_stop_q, timer_stop_d;
  logic                     start_dly_q, start_dly_d;
  logic [1:0]               timer_speed_q, timer_speed_d;
  logic [5:0]               timer_max_q, timer_max_d;
  logic                     show_valid_q, show_valid_d;
  logic [SYM_W-1:0]         show_symbol_q, show_symbol_d;
  logic                     game_over_q, game_over_d;
  logic                     win_q, win_d;

  logic [SYM_W*MAX_LEN-1:0] seq_q;
  logic                     seq_we;
  logic [15:0]              lfsr_val;
  logic [13:0]              lfsr_unused;
  logic [SYM_W-1:0]         seq_cur;
  logic                     done_ok;
  logic                     last_pos;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_val)
  );

  // Only the low bits pick symbols; the rest just feed the shift register.
  assign lfsr_unused = lfsr_val[15:2];

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    score_d       = score_q;
    idx_d         = idx_q;
    timer_start_d = 1'b0;
    timer_stop_d  = 1'b0;
    seq_we        = 1'b0;
    start_dly_d   = timer_start_q;

    seq_cur  = seq_q[idx_q*SYM_W +: SYM_W];
    last_pos = (idx_q == level_q - LVL_W'(1));
    // The timer clears done one cycle after start, so done is stale
    // during the start cycle and the one after it.
    done_ok  = timer_done && !timer_start_q && !start_dly_q;

    if (new_game) begin
      level_d      = '0;
      score_d      = '0;
      idx_d        = '0;
      timer_stop_d = 1'b1;
      state_d      = ST_EXTEND;
    end else begin
      unique case (state_q)
        ST_EXTEND: begin
          seq_we        = 1'b1;
          level_d       = level_q + LVL_W'(1);
          idx_d         = '0;
          timer_start_d = 1'b1;
          state_d       = ST_SHOW_ON;
        end
        ST_SHOW_ON: begin
          if (done_ok) begin
            timer_start_d = 1'b1;
            state_d       = ST_SHOW_OFF;
          end
        end
        ST_SHOW_OFF: begin
          if (done_ok) begin
            timer_start_d = 1'b1;
            if (last_pos) begin
              idx_d   = '0;
              state_d = ST_INPUT;
            end else begin
              idx_d   = idx_q + LVL_W'(1);
              state_d = ST_SHOW_ON;
            end
          end
        end
        ST_INPUT: begin
          // A press in the same cycle as done wins over the timeout.
          if (btn_valid) begin
            if (btn_symbol == seq_cur) begin
              if (last_pos) begin
                score_d = score_q + LVL_W'(1);
                if (level_q == MAX_LVL) begin
                  timer_stop_d = 1'b1;
                  state_d      = ST_WIN;
                end else begin
                  state_d = ST_EXTEND;
                end
              end else begin
                idx_d         = idx_q + LVL_W'(1);
                timer_start_d = 1'b1;
              end
            end else begin
              timer_stop_d = 1'b1;
              state_d      = ST_LOSE;
            end
          end else if (done_ok) begin
            timer_stop_d = 1'b1;
            state_d      = ST_LOSE;
          end
        end
        default: ;
      endcase
    end

    show_valid_d = (state_d == ST_SHOW_ON);
    if (!show_valid_d)
      show_symbol_d = '0;
    else if (seq_we && idx_d == level_q)
      // Symbol being written this cycle is not in seq_q yet.
      show_symbol_d = lfsr_val[SYM_W-1:0];
    else
      show_symbol_d = seq_q[idx_d*SYM_W +: SYM_W];

    unique case (state_d)
      ST_SHOW_ON:  timer_max_d = SHOW_TICKS;
      ST_SHOW_OFF: timer_max_d = GAP_TICKS;
      ST_INPUT:    timer_max_d = INPUT_TICKS;
      default:     timer_max_d = 6'd0;
    endcase

    timer_speed_d = speed_of(level_d);
    game_over_d   = (state_d == ST_LOSE);
    win_d         = (state_d == ST_WIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      level_q       <= '0;
      score_q       <= '0;
      idx_q         <= '0;
      timer_start_q <= 1'b0;
      timer_stop_q  <= 1'b0;
      start_dly_q   <= 1'b0;
      timer_speed_q <= '0;
      timer_max_q   <= '0;
      show_valid_q  <= 1'b0;
      show_symbol_q <= '0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      score_q       <= score_d;
      idx_q         <= idx_d;
      timer_start_q <= timer_start_d;
      timer_stop_q  <= timer_stop_d;
      start_dly_q   <= start_dly_d;
      timer_speed_q <= timer_speed_d;
      timer_max_q   <= timer_max_d;
      show_valid_q  <= show_valid_d;
      show_symbol_q <= show_symbol_d;
      game_over_q   <= game_over_d;
      win_q         <= win_d;
    end
  end

  // Sequence storage survives reset; entries are always written before read.
  always_ff @(posedge clock) begin
    if (seq_we) seq_q[level_q*SYM_W +: SYM_W] <= lfsr_val[SYM_W-1:0];
  end

  assign timer_start = timer_start_q;
  assign timer_stop  = timer_stop_q;
  assign timer_speed = timer_speed_q;
  assign timer_max   = timer_max_q;
  assign show_valid  = show_valid_q;
  assign show_symbol = show_symbol_q;
  assign level       = level_q;
  assign score       = score_q;
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule
